lb_txfifo: RTL and testbench

Local-bus slave that sits directly downstream of the APB-to-LB bridge and consumes its `lb_*` write and read strobes. Host writes to a data register are pushed into a parameterised FIFO, which drains onto a valid/ready stream toward the transmit datapath. The block exposes status and control registers. When the FIFO is full, it stalls the bridge through `lb_wready`, so the bridge's write wait-state path is exercised in normal operation.

---
 rtl/lb_txfifo_if.sv | 43 ++++
 rtl/lb_txfifo.sv | 161 ++++++++++++++++
 tb/tb_lb_txfifo.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lb_txfifo_if.sv
// lb_txfifo_if: local-bus write/read strobes plus the transmit stream and irq
// of lb_txfifo. The master side is the bridge / stream consumer; the slave
// side is the FIFO block.
interface lb_txfifo_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] lb_waddr;
  logic [DATA_W-1:0] lb_wdata;
  logic              lb_wen;
  logic [STRB_W-1:0] lb_wstrb;
  logic              lb_wready;
  logic [ADDR_W-1:0] lb_raddr;
  logic              lb_ren;
  logic [DATA_W-1:0] lb_rdata;
  logic              lb_rvalid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              irq;

  modport master (
    output lb_waddr, lb_wdata, lb_wen, lb_wstrb,
    input  lb_wready,
    output lb_raddr, lb_ren,
    input  lb_rdata, lb_rvalid,
    input  tx_data, tx_valid,
    output tx_ready,
    input  irq
  );

  modport slave (
    input  lb_waddr, lb_wdata, lb_wen, lb_wstrb,
    output lb_wready,
    input  lb_raddr, lb_ren,
    output lb_rdata, lb_rvalid,
    output tx_data, tx_valid,
    input  tx_ready,
    output irq
  );
endinterface

// File: rtl/lb_txfifo.sv
// lb_txfifo: local-bus slave that pushes TXDATA writes into a FIFO which
// drains onto a valid/ready stream. Stalls the bridge via lb_wready when full
// (unless DROP is set). Registers: TXDATA 0x000, STATUS 0x004, CTRL 0x008,
// and THRESH 0x00C when the macro LB_TXFIFO_IRQ_EN is defined (which also
// enables the level irq); without it irq is tied low.
module lb_txfifo #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input logic        clk,
  input logic        rst,
  lb_txfifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-3:0] W_TXDATA = '0;
  localparam logic [ADDR_W-3:0] W_STATUS = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] W_CTRL   = (ADDR_W-2)'(2);
`ifdef LB_TXFIFO_IRQ_EN
  localparam logic [ADDR_W-3:0] W_THRESH = (ADDR_W-2)'(3);
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              tx_valid_q;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q;
`ifdef LB_TXFIFO_IRQ_EN
  logic [7:0]        thresh_q, thresh_d;
  logic              irq_q;
`endif

  logic [ADDR_W-3:0] waddr_w, raddr_w;
  logic wr_txdata, full, empty, pop, wready;
  logic wr_acc, ctrl_wr, flush, ovf_clr, push_req, push, drop_hit, pop_eff;
  logic unused_addr_bits;

  assign waddr_w = bus.lb_waddr[ADDR_W-1:2];
  assign raddr_w = bus.lb_raddr[ADDR_W-1:2];
  assign unused_addr_bits = ^{bus.lb_waddr[1:0], bus.lb_raddr[1:0]};

  // Handshake and push/pop/flush decode for this cycle
  always_comb begin
    wr_txdata = bus.lb_wen && (waddr_w == W_TXDATA);
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    pop       = tx_valid_q && bus.tx_ready;
    // Only a TXDATA write into a full FIFO with no room freed stalls; reset forces ready.
    wready    = !rst || !(wr_txdata && full && !pop && !drop_q);
    wr_acc    = bus.lb_wen && wready;
    ctrl_wr   = wr_acc && (waddr_w == W_CTRL);
    flush     = ctrl_wr && bus.lb_wdata[0];
    ovf_clr   = ctrl_wr && bus.lb_wdata[2];
    push_req  = wr_acc && (waddr_w == W_TXDATA) && (|bus.lb_wstrb);
    // A push lost to a same-cycle flush neither lands nor counts as overflow.
    push      = push_req && (!full || pop) && !flush;
    drop_hit  = push_req && full && !pop && !flush;
    pop_eff   = pop && !flush;
  end

  // Next-state for pointers, count, head register and control bits
  always_comb begin
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop_eff);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop_eff);
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    // Head follows the new read pointer; bypass when that slot is being written now.
    tx_data_d = tx_data_q;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) tx_data_d = bus.lb_wdata;
      else                                tx_data_d = mem_q[rd_ptr_d];
    end
    drop_d = ctrl_wr ? bus.lb_wdata[1] : drop_q;
    // Overflow set has priority over a same-cycle clear.
    ovf_d  = drop_hit ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
`ifdef LB_TXFIFO_IRQ_EN
    thresh_d = (wr_acc && (waddr_w == W_THRESH)) ? bus.lb_wdata[7:0] : thresh_q;
`endif
  end

  // Read mux over the registered state; zero when no read is requested
  always_comb begin
    rdata_d = '0;
    if (bus.lb_ren) begin
      case (raddr_w)
        W_STATUS: begin
          rdata_d[CNT_W-1:0] = count_q;
          rdata_d[16]        = empty;
          rdata_d[17]        = full;
          rdata_d[18]        = ovf_q;
        end
        W_CTRL:   rdata_d[1] = drop_q;
`ifdef LB_TXFIFO_IRQ_EN
        W_THRESH: rdata_d[7:0] = thresh_q;
`endif
        default:  rdata_d = '0;
      endcase
    end
  end

  // FIFO storage, written at the tail on each accepted push
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.lb_wdata;
  end

  // Control/status registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      drop_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
`ifdef LB_TXFIFO_IRQ_EN
      thresh_q   <= '0;
      irq_q      <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_valid_q <= (count_d != '0);
      tx_data_q  <= tx_data_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= bus.lb_ren;
`ifdef LB_TXFIFO_IRQ_EN
      thresh_q   <= thresh_d;
      // Evaluated from the registered count, so it trails count by one cycle.
      irq_q      <= (8'(count_q) <= thresh_q) || ovf_q;
`endif
    end
  end

  assign bus.lb_wready = wready;
  assign bus.lb_rdata  = rdata_q;
  assign bus.lb_rvalid = rvalid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
`ifdef LB_TXFIFO_IRQ_EN
  assign bus.irq       = irq_q;
`else
  assign bus.irq       = 1'b0;
`endif
endmodule

// File: tb/tb_lb_txfifo.sv
// tb_lb_txfifo: directed table, hand-written corner sequences and a random
// run, all checked against a queue-based reference model of lb_txfifo.
module tb_lb_txfifo;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
`ifdef LB_TXFIFO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  lb_txfifo_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  lb_txfifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic obs_wready = 1'b1;

  // Reference model state
  logic [31:0] q [$];
  logic        m_ovf, m_drop, m_rv, m_irq;
  logic [7:0]  m_thresh;
  logic [31:0] m_rd;

  typedef struct {
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ren;
    logic [11:0] raddr;
    logic        rdy;
    logic        e_wr;
    logic        e_tv;
    logic [31:0] e_td;
    logic        e_rv;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_drop = 1'b0; m_rv = 1'b0; m_irq = 1'b0;
    m_thresh = 8'd0; m_rd = 32'd0;
  endtask

  function automatic logic model_wready();
    logic pop, full;
    pop  = (q.size() != 0) && bus.tx_ready;
    full = (q.size() == DEPTH);
    if (!rst) return 1'b1;
    return !(bus.lb_wen && (bus.lb_waddr[11:2] == 10'd0) && full && !pop && !m_drop);
  endfunction

  function automatic logic [31:0] readval(input logic [11:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a[11:2])
      10'd1: begin
        v[7:0] = 8'(q.size());
        v[16]  = (q.size() == 0);
        v[17]  = (q.size() == DEPTH);
        v[18]  = m_ovf;
      end
      10'd2: v[1] = m_drop;
      10'd3: if (IRQ_ON) v[7:0] = m_thresh;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic model_edge();
    logic pop, full, acc, push, drop_hit, flush, clr;
    logic [9:0] w;
    if (!rst) begin
      model_reset();
      return;
    end
    pop  = (q.size() != 0) && bus.tx_ready;
    full = (q.size() == DEPTH);
    acc  = bus.lb_wen && model_wready();
    w    = bus.lb_waddr[11:2];
    m_rv = bus.lb_ren;
    m_rd = bus.lb_ren ? readval(bus.lb_raddr) : 32'd0;
    m_irq = IRQ_ON && ((q.size() <= int'(m_thresh)) || m_ovf);
    push = 1'b0; drop_hit = 1'b0; flush = 1'b0; clr = 1'b0;
    if (acc && w == 10'd0 && bus.lb_wstrb != 4'd0) begin
      if (!full || pop) push = 1'b1;
      else              drop_hit = 1'b1;
    end
    if (acc && w == 10'd2) begin
      flush  = bus.lb_wdata[0];
      clr    = bus.lb_wdata[2];
      m_drop = bus.lb_wdata[1];
    end
    if (acc && w == 10'd3 && IRQ_ON) m_thresh = bus.lb_wdata[7:0];
    if (flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(bus.lb_wdata);
    end
    if (flush) drop_hit = 1'b0;
    if (drop_hit) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_regs();
    chk("tx_valid", 32'(bus.tx_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("tx_data", bus.tx_data, q[0]);
    chk("lb_rvalid", 32'(bus.lb_rvalid), 32'(m_rv));
    chk("lb_rdata", bus.lb_rdata, m_rd);
    chk("irq", 32'(bus.irq), 32'(m_irq));
  endtask

  task automatic set_in(input logic wen, input logic [11:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input logic ren, input logic [11:0] ra,
                        input logic rdy);
    bus.lb_wen = wen; bus.lb_waddr = wa; bus.lb_wdata = wd; bus.lb_wstrb = ws;
    bus.lb_ren = ren; bus.lb_raddr = ra; bus.tx_ready = rdy;
  endtask

  // One clock: check lb_wready before the edge, step the model, check registers after.
  task automatic cycle();
    #1;
    obs_wready = bus.lb_wready;
    chk("lb_wready", 32'(obs_wready), 32'(model_wready()));
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_wready", 32'(bus.lb_wready), 32'd1);
    set_in(1'b0, 12'h0, 32'h0, 4'h0, 1'b0, 12'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", bus.tx_data, 32'd0);
    chk("rst_rvalid", 32'(bus.lb_rvalid), 32'd0);
    chk("rst_rdata", bus.lb_rdata, 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_release_wready", 32'(bus.lb_wready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] alist [6];
    int bias;
    alist = '{12'h000, 12'h004, 12'h008, 12'h00c, 12'h020, 12'h003};

    tbl[0]  = '{1'b1, 12'h000, 32'hdeadbeef, 4'hf, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 32'hdeadbeef, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 12'h000, 32'h0,        4'h0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[2]  = '{1'b0, 12'h000, 32'h0,        4'h0, 1'b1, 12'h004, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00010000};
    tbl[3]  = '{1'b0, 12'h000, 32'h0,        4'h0, 1'b1, 12'h020, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0};
    tbl[4]  = '{1'b0, 12'h000, 32'h0,        4'h0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0};
    tbl[5]  = '{1'b1, 12'h000, 32'h12345678, 4'h0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[6]  = '{1'b1, 12'h008, 32'h00000002, 4'hf, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[7]  = '{1'b0, 12'h000, 32'h0,        4'h0, 1'b1, 12'h008, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00000002};
    tbl[8]  = '{1'b1, 12'h030, 32'hffffffff, 4'hf, 1'b1, 12'h004, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00010000};
    tbl[9]  = '{1'b1, 12'h003, 32'h55aa55aa, 4'h1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 32'h55aa55aa, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 12'h000, 32'h0,        4'h0, 1'b1, 12'h007, 1'b0, 1'b1, 1'b1, 32'h55aa55aa, 1'b1, 32'h00000001};

    set_in(1'b0, 12'h0, 32'h0, 4'h0, 1'b0, 12'h0, 1'b0);
    do_reset();

    // Directed table
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].wen, tbl[i].waddr, tbl[i].wdata, tbl[i].wstrb, tbl[i].ren, tbl[i].raddr, tbl[i].rdy);
      cycle();
      chk($sformatf("tbl%0d_wready", i), 32'(obs_wready), 32'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_tx_valid", i), 32'(bus.tx_valid), 32'(tbl[i].e_tv));
      if (tbl[i].e_tv) chk($sformatf("tbl%0d_tx_data", i), bus.tx_data, tbl[i].e_td);
      chk($sformatf("tbl%0d_rvalid", i), 32'(bus.lb_rvalid), 32'(tbl[i].e_rv));
      chk($sformatf("tbl%0d_rdata", i), bus.lb_rdata, tbl[i].e_rd);
    end

    // Fill to full, stall the ninth write, release it with a single pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 12'h000, 32'h100 + 32'(i), 4'hf, 1'b0, 12'h0, 1'b0);
      cycle();
    end
    set_in(1'b1, 12'h000, 32'h999, 4'hf, 1'b1, 12'h004, 1'b0);
    cycle();
    chk("stall_wready", 32'(obs_wready), 32'd0);
    chk("full_status", bus.lb_rdata, 32'h00020008);
    set_in(1'b1, 12'h000, 32'h999, 4'hf, 1'b0, 12'h0, 1'b0);
    cycle();
    chk("stall_hold_wready", 32'(obs_wready), 32'd0);
    set_in(1'b1, 12'h000, 32'h999, 4'hf, 1'b0, 12'h0, 1'b1);
    cycle();
    chk("stall_release_wready", 32'(obs_wready), 32'd1);
    chk("head_after_pop", bus.tx_data, 32'h101);
    set_in(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 12'h004, 1'b0);
    cycle();
    chk("count_stays_full", bus.lb_rdata, 32'h00020008);

    // DROP on full: accepted without stall, OVF set, then cleared via OVF_CLR
    set_in(1'b1, 12'h008, 32'h2, 4'hf, 1'b0, 12'h0, 1'b0);
    cycle();
    set_in(1'b1, 12'h000, 32'hcafebabe, 4'hf, 1'b0, 12'h0, 1'b0);
    cycle();
    chk("drop_wready", 32'(obs_wready), 32'd1);
    set_in(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 12'h004, 1'b0);
    cycle();
    chk("ovf_status", bus.lb_rdata, 32'h00060008);
    set_in(1'b1, 12'h008, 32'h6, 4'hf, 1'b0, 12'h0, 1'b0);
    cycle();
    set_in(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 12'h004, 1'b0);
    cycle();
    chk("ovf_cleared", bus.lb_rdata, 32'h00020008);

    // Reset while a TXDATA write is stalled
    set_in(1'b1, 12'h008, 32'h0, 4'hf, 1'b0, 12'h0, 1'b0);
    cycle();
    set_in(1'b1, 12'h000, 32'h777, 4'hf, 1'b0, 12'h0, 1'b0);
    cycle();
    chk("prereset_stall", 32'(obs_wready), 32'd0);
    do_reset();

    // FLUSH in the same cycle as a pop
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 12'h000, 32'h200 + 32'(i), 4'hf, 1'b0, 12'h0, 1'b0);
      cycle();
    end
    set_in(1'b1, 12'h008, 32'h1, 4'hf, 1'b0, 12'h0, 1'b1);
    cycle();
    chk("flush_tx_valid", 32'(bus.tx_valid), 32'd0);
    set_in(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 12'h004, 1'b1);
    cycle();
    chk("flush_status", bus.lb_rdata, 32'h00010000);
    chk("flush_no_extra_pop", 32'(bus.tx_valid), 32'd0);

    // Threshold irq: THRESH=2, push 4, drain to 2
    do_reset();
    set_in(1'b1, 12'h00c, 32'h2, 4'hf, 1'b0, 12'h0, 1'b0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 12'h000, 32'h300 + 32'(i), 4'hf, 1'b0, 12'h0, 1'b0);
      cycle();
    end
    set_in(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 12'h0, 1'b0);
    cycle();
    cycle();
    chk("irq_above_thresh", 32'(bus.irq), 32'd0);
    set_in(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 12'h0, 1'b1);
    cycle();
    cycle();
    chk("irq_lags_count", 32'(bus.irq), 32'd0);
    set_in(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 12'h00c, 1'b0);
    cycle();
    chk("irq_at_thresh", 32'(bus.irq), 32'(IRQ_ON));
    chk("thresh_read", bus.lb_rdata, IRQ_ON ? 32'd2 : 32'd0);

    // Random traffic against the model; stalled writes are held until accepted
    do_reset();
    bias = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) bias = $urandom_range(0, 4);
      if (!bus.lb_wen || obs_wready) begin
        bus.lb_wen   = ($urandom_range(0, 2) != 0);
        bus.lb_waddr = ($urandom_range(0, 1) == 1) ? 12'h000 : alist[$urandom_range(0, 5)];
        bus.lb_wdata = $urandom;
        if (bus.lb_waddr[11:2] == 10'd2) bus.lb_wdata[0] = ($urandom_range(0, 15) == 0);
        bus.lb_wstrb = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      bus.lb_ren   = ($urandom_range(0, 2) == 0);
      bus.lb_raddr = alist[$urandom_range(0, 5)];
      bus.tx_ready = ($urandom_range(0, 3) < bias);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
